// File: rtl/jtpang_objdma.sv
// jtpang_objdma -- object-attribute DMA engine for the Pang video path.
//
// On a dma_go rising edge the engine takes the Z80 bus (busrq/busak_n),
// copies 2^FLDW bytes from each of 2^OBJW object slots (slot stride
// 2^STRW bytes) of the CPU object RAM into a packed private object
// buffer, then releases the bus and pulses done.
//
// Ports:
//   clk, rst_n       system clock, synchronous active-low reset
//   cen              clock enable; all state advances only on cen
//   LVBL             vertical blank (active low), used only with
//                    JTPANG_OBJDMA_VBL_EN
//   dma_go           trigger, rising-edge sensitive
//   busrq / busak_n  bus request (active high) / bus acknowledge (active low)
//   src_addr/src_dout object RAM read port, 1-cen read latency
//   dst_addr/dst_din/dst_we  object buffer write port (dst_we qualified by cen)
//   busy, done       busy from acceptance to release; done one-cen pulse
//
// Configuration macro: JTPANG_OBJDMA_VBL_EN -- when defined, an accepted
// trigger waits in IDLE until LVBL is low before requesting the bus.
module jtpang_objdma #(
  parameter int OBJW = 7,
  parameter int FLDW = 2,
  parameter int STRW = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cen,
  input  logic                 LVBL,
  input  logic                 dma_go,
  output logic                 busrq,
  input  logic                 busak_n,
  output logic [OBJW+STRW-1:0] src_addr,
  input  logic [7:0]           src_dout,
  output logic [OBJW+FLDW-1:0] dst_addr,
  output logic [7:0]           dst_din,
  output logic                 dst_we,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = OBJW + FLDW;

  typedef enum logic [2:0] {IDLE, REQ, COPY, FLUSH, REL} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            re_q, re_d;       // bus was lost: re-read byte cnt-1 first
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            we_q, we_d;
  logic [CW-1:0]   daddr_q, daddr_d;
  logic [7:0]      din_q, din_d;
  logic            go_q, go_d;
  logic            go_edge;
  logic [CW-1:0]   rd_idx;
`ifdef JTPANG_OBJDMA_VBL_EN
  logic            pend_q, pend_d;   // trigger accepted, waiting for vblank
`else
  logic            unused_lvbl;
  assign unused_lvbl = LVBL;
`endif

  assign go_edge = dma_go & ~go_q;

  // While re-reading after a bus loss the address steps back one byte so
  // the byte whose read was corrupted is fetched again.
  assign rd_idx   = re_q ? cnt_q - CW'(1) : cnt_q;
  assign src_addr = {rd_idx[CW-1:FLDW], {(STRW-FLDW){1'b0}}, rd_idx[FLDW-1:0]};

  assign busrq    = (state_q == REQ) || (state_q == COPY) || (state_q == FLUSH);
  assign dst_addr = daddr_q;
  assign dst_din  = din_q;
  assign dst_we   = we_q;
  assign busy     = busy_q;
  assign done     = done_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    re_d    = re_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    we_d    = 1'b0;
    daddr_d = daddr_q;
    din_d   = din_q;
    go_d    = dma_go;
`ifdef JTPANG_OBJDMA_VBL_EN
    pend_d  = pend_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef JTPANG_OBJDMA_VBL_EN
        if ((!busy_q && go_edge) || pend_q) begin
          busy_d = 1'b1;
          if (!LVBL) begin
            pend_d  = 1'b0;
            state_d = REQ;
          end else begin
            pend_d  = 1'b1;
          end
        end
`else
        if (!busy_q && go_edge) begin
          busy_d  = 1'b1;
          state_d = REQ;
        end
`endif
      end
      REQ: begin
        if (!busak_n) begin
          state_d = COPY;
          cnt_d   = '0;
          re_d    = 1'b0;
        end
      end
      COPY: begin
        if (busak_n) begin
          // Bus lost: freeze; the byte in flight must be fetched again.
          if (cnt_q != '0) re_d = 1'b1;
        end else if (re_q) begin
          re_d = 1'b0;
        end else begin
          // src_dout now holds byte cnt-1 (address presented last cen).
          if (cnt_q != '0) begin
            we_d    = 1'b1;
            daddr_d = cnt_q - CW'(1);
            din_d   = src_dout;
          end
          if (cnt_q == '1) state_d = FLUSH;
          else             cnt_d   = cnt_q + CW'(1);
        end
      end
      FLUSH: begin
        we_d    = 1'b1;
        daddr_d = '1;
        din_d   = src_dout;
        state_d = REL;
      end
      REL: begin
        if (busak_n) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      re_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      daddr_q <= '0;
      din_q   <= '0;
      go_q    <= 1'b0;
`ifdef JTPANG_OBJDMA_VBL_EN
      pend_q  <= 1'b0;
`endif
    end else if (cen) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      re_q    <= re_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      we_q    <= we_d;
      daddr_q <= daddr_d;
      din_q   <= din_d;
      go_q    <= go_d;
`ifdef JTPANG_OBJDMA_VBL_EN
      pend_q  <= pend_d;
`endif
    end
  end

endmodule

// File: tb/tb_jtpang_objdma.sv
// Directed testbench for jtpang_objdma. Models the CPU object RAM
// (byte at address k holds k[7:0], reads 0xEE while the CPU owns the bus)
// and the private object buffer (captures every cen-qualified write).
module tb_jtpang_objdma;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cen = 1'b0;
  logic        LVBL = 1'b0;
  logic        dma_go = 1'b0;
  logic        busak_n = 1'b1;
  logic        busrq;
  logic [11:0] src_addr;
  logic [7:0]  src_dout = 8'h00;
  logic [8:0]  dst_addr;
  logic [7:0]  dst_din;
  logic        dst_we;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_count = 0;
  int rq_cens = 0;
  int done_cens = 0;
  logic [7:0] dbuf [512];
  logic clr_buf = 1'b0;

  jtpang_objdma #(.OBJW(7), .FLDW(2), .STRW(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cen      (cen),
    .LVBL     (LVBL),
    .dma_go   (dma_go),
    .busrq    (busrq),
    .busak_n  (busak_n),
    .src_addr (src_addr),
    .src_dout (src_dout),
    .dst_addr (dst_addr),
    .dst_din  (dst_din),
    .dst_we   (dst_we),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // cen is high on every other rising edge; it changes 2 ns after a rising
  // edge so it is stable at the falling edge before the edge it qualifies.
  initial forever begin
    @(posedge clk);
    #2 cen = ~cen;
  end

  // Object RAM: one-cen read latency.
  always @(posedge clk)
    if (cen) src_dout <= busak_n ? 8'hEE : src_addr[7:0];

  // Object buffer and event counters, sampled before each active edge.
  always @(negedge clk) begin
    if (clr_buf) begin
      for (int i = 0; i < 512; i++) dbuf[i] = 8'h55;
    end else if (cen && dst_we) begin
      dbuf[dst_addr] = dst_din;
      wr_count++;
    end
    if (cen && busrq) rq_cens++;
    if (cen && done)  done_cens++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next cen-qualified rising edge.
  task automatic cyc();
    @(negedge clk);
    while (!cen) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_buf();
    clr_buf = 1'b1;
    @(negedge clk);
    #1 clr_buf = 1'b0;
    cyc();
  endtask

  task automatic wait_rq_low(input string tag);
    int k = 0;
    while (busrq !== 1'b0 && k < 2000) begin
      cyc();
      k++;
    end
    chk(tag, busrq, 0);
  endtask

  task automatic wait_wr(input string tag, input int base, input int n);
    int k = 0;
    while ((wr_count - base) < n && k < 2000) begin
      cyc();
      k++;
    end
    chk(tag, ((wr_count - base) >= n) ? 1 : 0, 1);
  endtask

  // dst[4*o+f] must equal src[32*o+f] = (32*o+f)[7:0]
  function automatic int buf_errs();
    int e = 0;
    for (int i = 0; i < 512; i++)
      if (dbuf[i] !== 8'(((i / 4) * 32) + (i % 4))) e++;
    return e;
  endfunction

  task automatic start_xfer();
    dma_go = 1'b1;
    cyc();
    dma_go = 1'b0;
    repeat (3) cyc();
    busak_n = 1'b0;
  endtask

  initial begin
    int w0, w1, r0, d0;

    // Reset state
    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_busrq", busrq, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dst_we", dst_we, 0);
    chk("rst_src_addr", src_addr, 0);
    chk("rst_dst_addr", dst_addr, 0);
    chk("rst_dst_din", dst_din, 0);
    rst_n = 1'b1;
    cyc();

    // Full transfer
    clear_buf();
    w0 = wr_count; r0 = rq_cens; d0 = done_cens;
    dma_go = 1'b1;
    cyc();
    chk("t1_busrq_rise", busrq, 1);
    chk("t1_busy_rise", busy, 1);
    dma_go = 1'b0;
    repeat (3) cyc();
    chk("t1_no_we_req", dst_we, 0);
    busak_n = 1'b0;
    wait_rq_low("t1_busrq_fall");
    chk("t1_busrq_cens", rq_cens - r0, 517);
    chk("t1_busy_rel", busy, 1);
    busak_n = 1'b1;
    cyc();
    chk("t1_done_hi", done, 1);
    chk("t1_busy_lo", busy, 0);
    cyc();
    chk("t1_done_lo", done, 0);
    chk("t1_writes", wr_count - w0, 512);
    chk("t1_buf_errs", buf_errs(), 0);
    chk("t1_done_cnt", done_cens - d0, 1);

    // Bus never granted
    w0 = wr_count;
    dma_go = 1'b1;
    cyc();
    dma_go = 1'b0;
    repeat (1000) cyc();
    chk("t2_busrq_held", busrq, 1);
    chk("t2_busy_held", busy, 1);
    chk("t2_no_writes", wr_count - w0, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("t2_rst_busrq", busrq, 0);
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();

    // Trigger again mid-copy and hold it high
    clear_buf();
    w0 = wr_count; d0 = done_cens;
    start_xfer();
    wait_wr("t3_wait100", w0, 100);
    dma_go = 1'b1;
    wait_rq_low("t3_busrq_fall");
    busak_n = 1'b1;
    cyc();
    chk("t3_done_hi", done, 1);
    repeat (600) cyc();
    chk("t3_done_cnt", done_cens - d0, 1);
    chk("t3_writes", wr_count - w0, 512);
    chk("t3_busrq_idle", busrq, 0);
    chk("t3_busy_idle", busy, 0);
    chk("t3_buf_errs", buf_errs(), 0);
    dma_go = 1'b0;
    cyc();

    // Bus lost for 5 cen during the copy
    clear_buf();
    w0 = wr_count;
    start_xfer();
    wait_wr("t4_wait200", w0, 200);
    busak_n = 1'b1;
    cyc();
    w1 = wr_count;
    repeat (4) cyc();
    chk("t4_gap_writes", wr_count - w1, 0);
    chk("t4_gap_busrq", busrq, 1);
    chk("t4_gap_we", dst_we, 0);
    busak_n = 1'b0;
    wait_rq_low("t4_busrq_fall");
    busak_n = 1'b1;
    cyc();
    chk("t4_done_hi", done, 1);
    cyc();
    chk("t4_writes", wr_count - w0, 512);
    chk("t4_buf_errs", buf_errs(), 0);

    // Reset mid-copy, then a fresh transfer
    clear_buf();
    w0 = wr_count;
    start_xfer();
    wait_wr("t5_wait300", w0, 300);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("t5_rst_busrq", busrq, 0);
    chk("t5_rst_busy", busy, 0);
    busak_n = 1'b1;
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    clear_buf();
    w0 = wr_count; d0 = done_cens;
    start_xfer();
    wait_rq_low("t5_busrq_fall");
    busak_n = 1'b1;
    cyc();
    chk("t5_done_hi", done, 1);
    cyc();
    chk("t5_writes", wr_count - w0, 512);
    chk("t5_buf_errs", buf_errs(), 0);
    chk("t5_done_cnt", done_cens - d0, 1);

    // Trigger outside vertical blank
    LVBL = 1'b1;
    dma_go = 1'b1;
    cyc();
    dma_go = 1'b0;
`ifdef JTPANG_OBJDMA_VBL_EN
    chk("t6_busrq_wait", busrq, 0);
    chk("t6_busy_pend", busy, 1);
    repeat (5) cyc();
    chk("t6_busrq_still", busrq, 0);
    LVBL = 1'b0;
    cyc();
    chk("t6_busrq_vbl", busrq, 1);
`else
    chk("t6_busrq_novbl", busrq, 1);
    chk("t6_busy", busy, 1);
`endif
    rst_n = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    LVBL = 1'b0;
    cyc();
    chk("t6_idle_busrq", busrq, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jtpang_objdma.md
# jtpang_objdma

Object-attribute DMA engine for the Pang video path. It sits between the CPU-side object RAM and the object line-drawing logic. When the main CPU triggers `dma_go`, it takes the CPU bus through the Z80 `busrq_n`/`busak_n` handshake. It then copies a fixed window of object attributes into a private object buffer and releases the bus.

## Interface
Parameters:
- `OBJW`, 7, log2 of object count (128 objects).
- `FLDW`, 2, log2 of bytes copied per object (4 bytes).
- `STRW`, 5, log2 of source stride per object in bytes (32-byte slots).

Ports:
- `clk`  in  1  system clock. One clock domain; reset is synchronous and active-low.
- `rst_n`  in  1  synchronous active-low reset.
- `cen`  in  1  clock enable (pixel cen, 6 MHz); the FSM and counters advance only on `cen`.
- `LVBL`  in  1  vertical blank, active low; used only under the configuration macro.
- `dma_go`  in  1  trigger from the main CPU decoder; a rising-edge pulse.
- `busrq`  out  1  bus request, active high; inverted externally to `busrq_n`.
- `busak_n`  in  1  CPU bus acknowledge, active low.
- `src_addr`  out  OBJW+STRW  object RAM read address.
- `src_dout`  in  8  object RAM data; 1-cen read latency.
- `dst_addr`  out  OBJW+FLDW  object buffer write address.
- `dst_din`  out  8  object buffer write data.
- `dst_we`  out  1  object buffer write strobe; qualified with `cen`.
- `busy`  out  1  high from trigger acceptance until the bus is released.
- `done`  out  1  one-`cen` pulse after the bus is released.

## Operation
- States are `IDLE`, `REQ`, `COPY`, `FLUSH` and `REL`.
- `IDLE`: a `dma_go` rising edge is accepted, sets `busy=1` and moves to `REQ`.
- `REQ`: `busrq=1`. The FSM holds here until `busak_n` is sampled low on a `cen`, then moves to `COPY` with the counter `cnt=0`.
- `COPY`: each `cen` does the following.
  - Presents `src_addr = {cnt[OBJW+FLDW-1:FLDW], {STRW-FLDW{1'b0}}, cnt[FLDW-1:0]}`.
  - Writes the previous cycle's `src_dout` to `dst_addr=cnt-1` with `dst_we=1`. No write happens on the first `COPY` cycle.
  - When `cnt` reaches all-ones, the FSM moves to `FLUSH`.
- `FLUSH`: writes the last byte to `dst_addr` all-ones, then moves to `REL`.
- `REL`: `busrq=0`. When `busak_n` is sampled high, the FSM pulses `done`, clears `busy` and returns to `IDLE`.
- `cnt` is OBJW+FLDW bits wide and wraps naturally. No address may exceed the window.
- A `dma_go` edge while `busy=1` is ignored: not queued, and it does not restart the copy.
- If `busak_n` goes high during `COPY` (bus lost), the FSM freezes `cnt` and holds `dst_we=0` until `busak_n` returns low. The in-flight byte is then re-read.
- If `dma_go` is held high continuously, only one transfer occurs. A new transfer needs a low-to-high edge.
- `busrq` only falls in `REL`. It never drops mid-copy, except on reset.

## Timing
- Reset values: `busrq=0`, `busy=0`, `done=0`, `dst_we=0`, `src_addr=0`, `dst_addr=0`, `dst_din=0`. The FSM is in `IDLE` and the edge detector is cleared.
- Reset asserted mid-transfer: `busrq` drops on the next `clk` edge regardless of `cen`. The buffer contents are left undefined.
- `dma_go` is edge-detected on `cen`. The `busrq` rise follows 1 `cen` after the edge.
- Copy length: 2^(OBJW+FLDW) writes. `COPY` plus `FLUSH` take 2^(OBJW+FLDW)+1 `cen` cycles when the bus is not lost. With defaults this is 512 writes in 513 `cen`.
- `src_dout` must be valid on the `cen` following the address; `dst_din` is registered.
- `done` is high for exactly one `cen` period, on the `cen` where `busak_n` is seen high in `REL`.

## Configuration
- `JTPANG_OBJDMA_VBL_EN` defined: an accepted `dma_go` edge is held pending in `IDLE` until `LVBL=0`, and only then enters `REQ`. `busy` rises at acceptance.
- `JTPANG_OBJDMA_VBL_EN` undefined: `LVBL` is ignored and `REQ` is entered immediately.

## Test plan
- Reset then `dma_go` pulse; `busak_n` low 3 `cen` after `busrq`. Source byte k = k[7:0] in each slot. Required: `dst` addresses 0..511 are written, with `dst[4*o+f] = src[32*o+f]`. `busrq` is high for 513+ `cen`, then one `done` pulse.
- `busak_n` never asserted: `busrq` and `busy` stay high, with no `dst_we` for 1000 `cen`.
- Second `dma_go` at write 100: exactly 512 writes total and a single `done`.
- `busak_n` high for 5 `cen` at write 200: no writes during the gap, and the final buffer still matches the source exactly.
- `rst_n` low at write 300: `busrq=0` next `clk`, `busy=0`. A fresh `dma_go` then completes a full 512-byte copy.
- With `JTPANG_OBJDMA_VBL_EN` defined, `dma_go` at `LVBL=1`: no `busrq` until `LVBL` falls, then `busrq` 1 `cen` later.
